beam_sum: RTL and testbench
===========================

# beam_sum

Delay-and-sum combiner stage that sits directly downstream of the 8-channel delay module. It captures one sample from each of the eight delayed PCM channels on a sample strobe and serially accumulates the enabled channels through a single adder. It then scales the sum by a selectable power of two and presents one 19-bit beamformed sample on a valid/ready output interface, holding it until the consumer accepts it.

## Interface
Parameters:
- `NCH`, 8: channel count; fixed, not overridable.
- `DW`, 19: PCM sample width in bits; fixed, not overridable.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pcm_valid` in 1: one-cycle strobe; `pcm_data_0..7` hold a new sample set.
- `pcm_data_0` … `pcm_data_7` in 19 each: signed two's-complement delayed PCM samples.
- `chan_mask` in 8: bit k=1 includes channel k; sampled together with the data.
- `gain_shift` in 2: output gain select; sampled together with the data.
- `out_ready` in 1: consumer can accept `beam_data`.
- `beam_valid` out 1: `beam_data` is valid.
- `beam_data` out 19: signed beamformed sample.
- `beam_clip` out 1: the held sample was clamped.
- `busy` out 1: high in every state except IDLE.
- `overrun_cnt` out 8: count of dropped strobes, saturating.

## Operation
- FSM states are IDLE, ACCUM, SCALE and HOLD.
- IDLE:
  - On `pcm_valid`, register all 8 samples, `chan_mask` and `gain_shift`.
  - Clear the accumulator, set channel index to 0 and go to ACCUM.
- ACCUM:
  - Each cycle, acc += masked channel[idx], where a masked-out channel contributes 0. Each channel is sign-extended to 22 bits.
  - idx increments 0→7; after the idx=7 add, go to SCALE.
- SCALE:
  - Compute acc >>> (3 − gain_shift) as an arithmetic shift, so the result rounds toward −inf.
  - gain_shift 0 = mean of 8; 3 = raw sum.
  - Register the result into `beam_data`, set `beam_valid` = 1 and go to HOLD.
- HOLD:
  - `beam_data`, `beam_valid` and `beam_clip` stay stable until `beam_valid && out_ready` is high at a clock edge.
  - On that edge, clear `beam_valid` and go to IDLE.
  - If `pcm_valid` is also high on that same edge, capture the new set and go directly to ACCUM.
- Overrun:
  - `pcm_valid` while in ACCUM or SCALE, or in HOLD without a completing transfer, drops the sample.
  - A drop increments `overrun_cnt`, which saturates at 255. Captured data is never overwritten.
- Accumulator is 22 bits signed, so the sum of 8 full-scale samples cannot overflow before scaling.
- Reset (asynchronous, at any point including mid-ACCUM):
  - State returns to IDLE and the accumulator and capture registers clear.
  - `beam_valid`, `beam_data`, `beam_clip`, `busy` and `overrun_cnt` all read 0.

## Timing
- The edge that samples `pcm_valid` is edge 0.
- Channel k is added on edge 1+k (edges 1–8).
- SCALE registers the output on edge 9; `beam_valid` is high after edge 9, giving 9 edges of latency.
- Minimum sample period is 10 cycles, with `out_ready` held high and a back-to-back strobe on the transfer edge.
- `busy` is registered; it rises after edge 0 and falls after the transfer edge unless a new set was captured on that edge.
- No combinational path exists from any input to any output.

## Configuration
- The macro `BEAM_SUM_SAT_EN` selects how an out-of-range scaled result is handled.
- Defined:
  - A scaled result outside [−262144, 262143] is clamped to the nearest limit.
  - `beam_clip` = 1 for that held sample.
- Undefined:
  - The low 19 bits are taken, so the result wraps.
  - `beam_clip` is tied to 0.
- Clamping can occur only when gain_shift > 0.

## Test plan
- All channels 1000, mask 0xFF, gain_shift 0, `out_ready` high → `beam_data` = 1000, `beam_valid` high after edge 9 for one cycle, `beam_clip` 0.
- All channels 262143, mask 0xFF, gain_shift 3 → with `BEAM_SUM_SAT_EN`: `beam_data` = 262143 and `beam_clip` = 1; without it: `beam_data` = −8 and `beam_clip` = 0.
- mask 0x01, ch0 = −801, others 5000, gain_shift 0 → `beam_data` = −101, showing masking and floor rounding.
- `out_ready` held low 30 cycles with `pcm_valid` strobed every 12 cycles:
  - `beam_data` stays stable.
  - `overrun_cnt` = 2.
  - After `out_ready` rises, one transfer occurs, then IDLE.
- `pcm_valid` on the same edge as a completing HOLD transfer → the new set is captured with no overrun increment, and the next output arrives 9 edges later.
- `rst` pulled low during ACCUM (edge 4) → all outputs 0 immediately (asynchronous); after release, a fresh strobe yields a correct result.

Source files
------------

// File: rtl/beam_sum.sv
// Delay-and-sum combiner: captures eight delayed PCM channels, serially sums the
// enabled ones, scales by a power of two and holds the result on a valid/ready port.
// Define BEAM_SUM_SAT_EN to clamp out-of-range results (and flag beam_clip) instead of wrapping.
module beam_sum #(
   localparam int unsigned NCH = 8,
   localparam int unsigned DW  = 19
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pcm_valid,
   input  logic [DW-1:0] pcm_data_0,
   input  logic [DW-1:0] pcm_data_1,
   input  logic [DW-1:0] pcm_data_2,
   input  logic [DW-1:0] pcm_data_3,
   input  logic [DW-1:0] pcm_data_4,
   input  logic [DW-1:0] pcm_data_5,
   input  logic [DW-1:0] pcm_data_6,
   input  logic [DW-1:0] pcm_data_7,
   input  logic [7:0]    chan_mask,
   input  logic [1:0]    gain_shift,
   input  logic          out_ready,
   output logic          beam_valid,
   output logic [DW-1:0] beam_data,
   output logic          beam_clip,
   output logic          busy,
   output logic [7:0]    overrun_cnt
);

   localparam int unsigned AW = 22;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_SCALE,
      S_HOLD
   } state_t;

   state_t state, state_nxt;

   logic [DW-1:0]        pcm_in [NCH];
   logic [DW-1:0]        cap    [NCH];
   logic [7:0]           mask_q;
   logic [1:0]           gain_q;
   logic signed [AW-1:0] acc;
   logic [2:0]           idx;

   logic                 capture;
   logic                 add_en;
   logic                 load_out;
   logic                 xfer;
   logic                 drop;

   logic [DW-1:0]        sel;
   logic signed [AW-1:0] addend;
   logic [1:0]           shamt;
   logic [DW-1:0]        res;

   assign pcm_in[0] = pcm_data_0;
   assign pcm_in[1] = pcm_data_1;
   assign pcm_in[2] = pcm_data_2;
   assign pcm_in[3] = pcm_data_3;
   assign pcm_in[4] = pcm_data_4;
   assign pcm_in[5] = pcm_data_5;
   assign pcm_in[6] = pcm_data_6;
   assign pcm_in[7] = pcm_data_7;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      add_en    = 1'b0;
      load_out  = 1'b0;
      xfer      = 1'b0;
      drop      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (pcm_valid) begin
               capture   = 1'b1;
               state_nxt = S_ACCUM;
            end
         end
         S_ACCUM: begin
            add_en = 1'b1;
            drop   = pcm_valid;
            if (idx == 3'(NCH - 1)) state_nxt = S_SCALE;
         end
         S_SCALE: begin
            load_out  = 1'b1;
            drop      = pcm_valid;
            state_nxt = S_HOLD;
         end
         S_HOLD: begin
            // a strobe coinciding with the transfer edge starts the next set directly
            if (beam_valid && out_ready) begin
               xfer = 1'b1;
               if (pcm_valid) begin
                  capture   = 1'b1;
                  state_nxt = S_ACCUM;
               end else begin
                  state_nxt = S_IDLE;
               end
            end else begin
               drop = pcm_valid;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      sel    = cap[idx];
      addend = mask_q[idx] ? {{(AW - DW){sel[DW-1]}}, sel} : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < NCH; k++) cap[k] <= '0;
         mask_q <= '0;
         gain_q <= '0;
         acc    <= '0;
         idx    <= '0;
      end else if (capture) begin
         for (int unsigned k = 0; k < NCH; k++) cap[k] <= pcm_in[k];
         mask_q <= chan_mask;
         gain_q <= gain_shift;
         acc    <= '0;
         idx    <= '0;
      end else if (add_en) begin
         acc <= acc + addend;
         idx <= idx + 3'd1;
      end
   end

   assign shamt = 2'd3 - gain_q;

`ifdef BEAM_SUM_SAT_EN
   localparam logic signed [AW-1:0] OUT_MAX = AW'((2 ** (DW - 1)) - 1);
   localparam logic signed [AW-1:0] OUT_MIN = AW'(-(2 ** (DW - 1)));

   logic signed [AW-1:0] scaled;
   logic                 clip;
   logic                 clip_q;

   always_comb begin
      scaled = acc >>> shamt;
      clip   = 1'b0;
      res    = scaled[DW-1:0];
      if (scaled > OUT_MAX) begin
         res  = OUT_MAX[DW-1:0];
         clip = 1'b1;
      end else if (scaled < OUT_MIN) begin
         res  = OUT_MIN[DW-1:0];
         clip = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          clip_q <= 1'b0;
      else if (load_out) clip_q <= clip;
   end

   assign beam_clip = clip_q;
`else
   always_comb begin
      res = DW'(acc >>> shamt);
   end

   assign beam_clip = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beam_valid  <= 1'b0;
         beam_data   <= '0;
         busy        <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         if (load_out) begin
            beam_data  <= res;
            beam_valid <= 1'b1;
         end else if (xfer) begin
            beam_valid <= 1'b0;
         end
         busy <= (state_nxt != S_IDLE);
         if (drop && (overrun_cnt != '1)) overrun_cnt <= overrun_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_beam_sum.sv
// Directed bench for beam_sum: reset, scaling/masking/rounding, clamp or wrap,
// backpressure with dropped strobes, back-to-back capture and mid-sum reset.
module tb_beam_sum;

   logic        clk = 1'b0;
   logic        rst;
   logic        pcm_valid;
   logic [18:0] pcm_data_0, pcm_data_1, pcm_data_2, pcm_data_3;
   logic [18:0] pcm_data_4, pcm_data_5, pcm_data_6, pcm_data_7;
   logic [7:0]  chan_mask;
   logic [1:0]  gain_shift;
   logic        out_ready;
   logic        beam_valid;
   logic [18:0] beam_data;
   logic        beam_clip;
   logic        busy;
   logic [7:0]  overrun_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int ch [8];

   beam_sum dut (
      .clk         (clk),
      .rst         (rst),
      .pcm_valid   (pcm_valid),
      .pcm_data_0  (pcm_data_0),
      .pcm_data_1  (pcm_data_1),
      .pcm_data_2  (pcm_data_2),
      .pcm_data_3  (pcm_data_3),
      .pcm_data_4  (pcm_data_4),
      .pcm_data_5  (pcm_data_5),
      .pcm_data_6  (pcm_data_6),
      .pcm_data_7  (pcm_data_7),
      .chan_mask   (chan_mask),
      .gain_shift  (gain_shift),
      .out_ready   (out_ready),
      .beam_valid  (beam_valid),
      .beam_data   (beam_data),
      .beam_clip   (beam_clip),
      .busy        (busy),
      .overrun_cnt (overrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic fill(input int v);
      for (int i = 0; i < 8; i++) ch[i] = v;
   endtask

   task automatic drive(input logic [7:0] m, input logic [1:0] g);
      pcm_data_0 = 19'(ch[0]);
      pcm_data_1 = 19'(ch[1]);
      pcm_data_2 = 19'(ch[2]);
      pcm_data_3 = 19'(ch[3]);
      pcm_data_4 = 19'(ch[4]);
      pcm_data_5 = 19'(ch[5]);
      pcm_data_6 = 19'(ch[6]);
      pcm_data_7 = 19'(ch[7]);
      chan_mask  = m;
      gain_shift = g;
      pcm_valid  = 1'b1;
   endtask

   // One full transaction with out_ready high: strobe, 9-edge latency, one-cycle valid.
   task automatic run_and_check(input string tag, input logic [7:0] m, input logic [1:0] g,
                                input int exp_data, input int exp_clip);
      drive(m, g);
      tick();
      pcm_valid = 1'b0;
      chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
      repeat (8) tick();
      chk({tag, "_valid_e8"}, 32'(beam_valid), 32'd0);
      tick();
      chk({tag, "_valid_e9"}, 32'(beam_valid), 32'd1);
      chk({tag, "_data"}, 32'($signed(beam_data)), exp_data);
      chk({tag, "_clip"}, 32'(beam_clip), exp_clip);
      tick();
      chk({tag, "_valid_e10"}, 32'(beam_valid), 32'd0);
      chk({tag, "_busy_e10"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst       = 1'b0;
      pcm_valid = 1'b0;
      out_ready = 1'b1;
      fill(0);
      drive(8'h00, 2'd0);
      pcm_valid = 1'b0;
      #1;
      chk("rst_valid", 32'(beam_valid), 32'd0);
      chk("rst_data", 32'(beam_data), 32'd0);
      chk("rst_clip", 32'(beam_clip), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovr", 32'(overrun_cnt), 32'd0);
      repeat (2) tick();
      rst = 1'b1;
      tick();

      fill(1000);
      run_and_check("mean1000", 8'hFF, 2'd0, 1000, 0);

      fill(262143);
`ifdef BEAM_SUM_SAT_EN
      run_and_check("pos_full_g3", 8'hFF, 2'd3, 262143, 1);
`else
      run_and_check("pos_full_g3", 8'hFF, 2'd3, -8, 0);
`endif

      fill(-262144);
`ifdef BEAM_SUM_SAT_EN
      run_and_check("neg_full_g3", 8'hFF, 2'd3, -262144, 1);
`else
      run_and_check("neg_full_g3", 8'hFF, 2'd3, 0, 0);
`endif

      fill(262143);
      run_and_check("pos_full_g0", 8'hFF, 2'd0, 262143, 0);

      fill(5000);
      ch[0] = -801;
      run_and_check("mask01_floor", 8'h01, 2'd0, -101, 0);

      for (int i = 0; i < 8; i++) ch[i] = 100 * (i + 1);
      run_and_check("maskAA_g1", 8'hAA, 2'd1, 500, 0);

      fill(-3);
      run_and_check("neg3_g2", 8'hFF, 2'd2, -12, 0);

      // Backpressure: strobes at edges 12 and 24 arrive while holding and are dropped.
      out_ready = 1'b0;
      fill(8);
      drive(8'hFF, 2'd0);
      tick();
      pcm_valid = 1'b0;
      fill(500);
      for (int c = 1; c <= 30; c++) begin
         if (c == 12 || c == 24) drive(8'hFF, 2'd3);
         tick();
         pcm_valid = 1'b0;
         if (c == 12 || c == 24 || c == 30) begin
            chk("bp_data", 32'($signed(beam_data)), 32'd8);
            chk("bp_valid", 32'(beam_valid), 32'd1);
            chk("bp_busy", 32'(busy), 32'd1);
         end
         if (c == 12) chk("bp_ovr_1", 32'(overrun_cnt), 32'd1);
      end
      chk("bp_ovr_2", 32'(overrun_cnt), 32'd2);
      out_ready = 1'b1;
      tick();
      chk("bp_xfer_valid", 32'(beam_valid), 32'd0);
      chk("bp_xfer_busy", 32'(busy), 32'd0);
      tick();
      chk("bp_idle_valid", 32'(beam_valid), 32'd0);
      chk("bp_idle_busy", 32'(busy), 32'd0);
      chk("bp_idle_ovr", 32'(overrun_cnt), 32'd2);

      // Back-to-back: new strobe exactly on the transfer edge.
      fill(16);
      drive(8'hFF, 2'd0);
      tick();
      pcm_valid = 1'b0;
      repeat (9) tick();
      chk("b2b_first_valid", 32'(beam_valid), 32'd1);
      chk("b2b_first_data", 32'($signed(beam_data)), 32'd16);
      fill(-40);
      drive(8'hFF, 2'd0);
      tick();
      pcm_valid = 1'b0;
      chk("b2b_xfer_valid", 32'(beam_valid), 32'd0);
      chk("b2b_xfer_busy", 32'(busy), 32'd1);
      chk("b2b_xfer_ovr", 32'(overrun_cnt), 32'd2);
      repeat (8) tick();
      chk("b2b_valid_e8", 32'(beam_valid), 32'd0);
      tick();
      chk("b2b_second_valid", 32'(beam_valid), 32'd1);
      chk("b2b_second_data", 32'($signed(beam_data)), -40);
      tick();
      chk("b2b_done_valid", 32'(beam_valid), 32'd0);
      chk("b2b_done_busy", 32'(busy), 32'd0);

      // Asynchronous reset in the middle of accumulation.
      fill(7);
      drive(8'hFF, 2'd0);
      tick();
      pcm_valid = 1'b0;
      repeat (4) tick();
      #2;
      rst = 1'b0;
      #1;
      chk("arst_valid", 32'(beam_valid), 32'd0);
      chk("arst_data", 32'(beam_data), 32'd0);
      chk("arst_clip", 32'(beam_clip), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_ovr", 32'(overrun_cnt), 32'd0);
      tick();
      chk("arst_hold_busy", 32'(busy), 32'd0);
      rst = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) ch[i] = 10 * (i + 1);
      run_and_check("post_rst", 8'hFF, 2'd3, 360, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
